// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and
// datapath select values.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWRITE,
        S_MEMWB,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LUI,
        S_AUIPC,
        S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_PASSB = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

endpackage

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Immediate-format select, decoded straight from the opcode in every state.
module imm_src_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:         imm_src = IMM_S;
            OP_BRANCH:        imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM with optional memory handshake,
// illegal-opcode trap and retired-instruction counter.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter bit          TRAP_HALT     = 1'b0,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IRWrite,
    output logic             PCUpdate,
    output logic             AdrSrc,
    output logic             Branch,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [2:0]       ImmSrc,
    output logic             illegal_op,
    output logic             retired,
    output logic [CNT_W-1:0] retire_cnt
);

    state_t           state;
    state_t           state_next;
    logic             ready;
    logic             retire_now;
    logic [CNT_W-1:0] cnt_q;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    imm_src_decoder u_imm_src_decoder (
        .op      (op),
        .imm_src (ImmSrc)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    state_next = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default:           state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_next = ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER, S_EXECUTEI, S_LUI, S_AUIPC, S_JAL:
                        state_next = S_ALUWB;
            S_JALR:     state_next = S_JAL;
            S_MEMWB, S_ALUWB, S_BRANCH:
                        state_next = S_FETCH;
            S_ILLEGAL:  state_next = TRAP_HALT ? S_ILLEGAL : S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    assign retire_now = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH)
                     || ((state == S_MEMWRITE) && ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            cnt_q <= '0;
        end else begin
            state <= state_next;
            if (retire_now) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Decoded from state rather than registered: FETCH enables and the retire
    // pulse follow mem_ready in the same cycle, and reset must blank them at once.
    always_comb begin
        mem_req    = 1'b0;
        IRWrite    = 1'b0;
        PCUpdate   = 1'b0;
        AdrSrc     = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ALUOp      = ALU_ADD;
        illegal_op = 1'b0;
        retired    = retire_now;
        retire_cnt = cnt_q;
        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                IRWrite   = ready;
                PCUpdate  = ready;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                ALUOp   = ALU_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_FUNCT;
            end
            S_LUI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_PASSB;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_ALUWB:   RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = SRCA_RD1;
                ALUOp   = ALU_SUB;
                Branch  = 1'b1;
            end
            S_JALR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                PCUpdate = 1'b1;
            end
            S_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
        if (!rst_n) begin
            mem_req    = 1'b0;
            IRWrite    = 1'b0;
            PCUpdate   = 1'b0;
            AdrSrc     = 1'b0;
            Branch     = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            ResultSrc  = '0;
            ALUSrcA    = '0;
            ALUSrcB    = '0;
            ALUOp      = '0;
            illegal_op = 1'b0;
            retired    = 1'b0;
            retire_cnt = '0;
        end
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Param MEM_HANDSHAKE, 1: 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready treated as 1.
REQ-002 Param TRAP_HALT, 0: 1 = illegal opcode parks in ILLEGAL until reset; 0 = skip and refetch.
REQ-003 Param CNT_W, 32: width of retire counter.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 op  in  7  opcode of instruction register.
REQ-007 mem_ready  in  1  memory completes access this cycle.
REQ-008 mem_req  out  1  memory access requested.
REQ-009 IRWrite, PCUpdate, AdrSrc, Branch, RegWrite, MemWrite  out  1 each  datapath enables/selects (AdrSrc 0=PC, 1=Result).
REQ-010 ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-011 ALUSrcA  out  2  00 PC, 01 OldPC, 10 rd1; ALUSrcB  out  2  00 rd2, 01 imm, 10 const 4.
REQ-012 ALUOp  out  2  00 add, 01 sub/branch, 10 funct-decoded, 11 pass B (lui).
REQ-013 ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; combinational from op, all states.
REQ-014 illegal_op  out  1  pulse/level in ILLEGAL; retired  out  1  one-cycle retire pulse; retire_cnt  out  CNT_W  retired-instruction count.

Function
REQ-015 Moore FSM; all outputs except ImmSrc depend only on state (and mem_ready for gated enables); outputs not listed for a state are 0.
REQ-016 FETCH: mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite and PCUpdate only when ready; ready -> DECODE, else stay.
REQ-017 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next by op: 0000011/0100011 MEMADR, 0110011 EXECUTER, 0010011 EXECUTEI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, 0010111 AUIPC, other ILLEGAL.
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; load -> MEMREAD, store -> MEMWRITE.
REQ-019 MEMREAD: mem_req, AdrSrc=1, ResultSrc=00; ready -> MEMWB, else stay.
REQ-020 MEMWRITE: mem_req, AdrSrc=1, ResultSrc=00, MemWrite held whole state; ready -> FETCH (retires).
REQ-021 MEMWB: ResultSrc=01, RegWrite -> FETCH (retires).
REQ-022 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both -> ALUWB.
REQ-023 LUI: ALUSrcB=01, ALUOp=11; AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00; both -> ALUWB.
REQ-024 ALUWB: ResultSrc=00, RegWrite -> FETCH (retires).
REQ-025 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch -> FETCH (retires).
REQ-026 JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 -> JAL; JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate -> ALUWB.
REQ-027 ILLEGAL: illegal_op=1; TRAP_HALT=0 -> FETCH after one cycle, no retire; TRAP_HALT=1 -> stay, illegal_op held.
REQ-028 retired pulses in the cycle a retiring state exits to FETCH; retire_cnt increments same edge, wraps 2^CNT_W-1 -> 0.
REQ-029 MEM_HANDSHAKE=0: every memory state lasts exactly one cycle regardless of mem_ready.

Reset
REQ-030 rst_n=0 at a rising edge: state <= FETCH, retire_cnt <= 0, from any state incl. mid-wait.
REQ-031 While rst_n=0 all outputs except ImmSrc forced 0; first cycle after release is FETCH.

Structure
REQ-032 Shared package/include holds state encodings, opcode constants and ResultSrc/ALUSrcA/ALUSrcB/ALUOp/ImmSrc encodings.
REQ-033 One sub-module imm_src_decoder (op -> ImmSrc, default 000).

Verification
REQ-034 add (op 0110011), ready=1: FETCH,DECODE,EXECUTER,ALUWB = 4 cycles; RegWrite once; retire_cnt 0->1.
REQ-035 lw, ready low 3 cycles in FETCH and 2 in MEMREAD: 10 cycles total; IRWrite/PCUpdate exactly once.
REQ-036 sw, MEM_HANDSHAKE=0, ready=0 constant: 4 cycles, MemWrite high exactly 1 cycle.
REQ-037 jalr: FETCH,DECODE,JALR,JAL,ALUWB; PCUpdate in FETCH and JAL only.
REQ-038 op 1111111: TRAP_HALT=0 -> illegal_op 1 cycle, back to FETCH, retire_cnt unchanged; TRAP_HALT=1 -> held until rst_n=0.
REQ-039 CNT_W=4, 16 retires -> retire_cnt 0; rst_n=0 during MEMREAD wait -> FETCH, counter 0.
